fifo_read_adapter: RTL and testbench

FIFO_READ_ADAPTER -- requirements
Module: fifo_read_adapter

---
 rtl/fifo_read_adapter_if.sv | 23 ++
 rtl/fifo_read_adapter.sv | 107 ++++++++++
 tb/tb_fifo_read_adapter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_adapter_if.sv
// Memory-core read port and downstream valid/ready stream
// grouped as one bundle; master is the adapter side.
interface fifo_read_adapter_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  empty;
   logic [DATA_WIDTH-1:0] mem_data_out;
   logic                  mem_valid_out;
   logic                  ren_in;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      input  empty, mem_data_out, mem_valid_out, out_ready,
      output ren_in, out_data, out_valid
   );

   modport slave (
      output empty, mem_data_out, mem_valid_out, out_ready,
      input  ren_in, out_data, out_valid
   );
endinterface

// File: rtl/fifo_read_adapter.sv
// Read adapter: issues memory-core FIFO reads into a small
// skid buffer and presents the buffer head downstream.
module fifo_read_adapter #(
   parameter int DATA_WIDTH = 16,
   parameter int BUF_DEPTH  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        flush,
   input  logic        enable,
   fifo_read_adapter_if.master bus,
   output logic [31:0] pop_cnt,
   output logic        err_spurious,
   output logic        err_overflow
);
   localparam int OW = $clog2(BUF_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

   state_t                state_q;
   logic [OW-1:0]         occ_q;
   logic [OW-1:0]         occ_d;
   logic                  inflight_q;
   logic [31:0]           pop_cnt_q;
   logic                  err_sp_q;
   logic                  err_ov_q;
   logic [DATA_WIDTH-1:0] fifo_q [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_d [BUF_DEPTH];

   logic          full;
   logic          pop;
   logic          acc;
   logic          wr;
   logic          ren;
   logic [OW:0]   pend;
   logic [OW-1:0] widx;

   assign full = (occ_q == OW'(BUF_DEPTH));
   assign pend = {1'b0, occ_q} + (OW+1)'(inflight_q);
   assign ren  = clk_en & ~flush & ~bus.empty & (state_q == ACTIVE)
               & enable & (pend < (OW+1)'(BUF_DEPTH));
   assign pop  = bus.out_valid & bus.out_ready & ~flush;
   assign acc  = bus.mem_valid_out & ~flush & (state_q != FLUSH);
   assign wr   = acc & (~full | pop);
   assign widx = occ_q - OW'(pop);
   assign occ_d = occ_q + OW'(wr) - OW'(pop);

   assign bus.ren_in    = ren;
   assign bus.out_valid = clk_en & (occ_q != '0);
   assign bus.out_data  = fifo_q[0];
   assign pop_cnt       = pop_cnt_q;
   assign err_spurious  = err_sp_q;
   assign err_overflow  = err_ov_q;

   // Shift buffer: pop moves entries toward the head, write lands at the tail
   always_comb begin
      fifo_d = fifo_q;
      if (pop) begin
         for (int i = 0; i < BUF_DEPTH - 1; i++) begin
            fifo_d[i] = fifo_q[i+1];
         end
      end
      for (int i = 0; i < BUF_DEPTH; i++) begin
         if (wr && (widx == OW'(i))) begin
            fifo_d[i] = bus.mem_data_out;
         end
      end
   end

   // Control FSM: flush overrides, FLUSH lasts exactly one cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else if (clk_en) begin
         if (flush) begin
            state_q <= FLUSH;
         end else begin
            unique case (state_q)
               IDLE:    if (enable) state_q <= ACTIVE;
               ACTIVE:  if (!enable && !inflight_q) state_q <= IDLE;
               FLUSH:   state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // Buffer, occupancy, outstanding read, pop counter and sticky errors
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occ_q      <= '0;
         inflight_q <= 1'b0;
         pop_cnt_q  <= '0;
         err_sp_q   <= 1'b0;
         err_ov_q   <= 1'b0;
         fifo_q     <= '{default: '0};
      end else if (clk_en) begin
         inflight_q <= ren;
         pop_cnt_q  <= pop_cnt_q + 32'(pop);
         fifo_q     <= fifo_d;
         occ_q      <= flush ? '0 : occ_d;
         if (acc && !inflight_q) err_sp_q <= 1'b1;
         if (acc && full && !pop) err_ov_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_fifo_read_adapter.sv
// Bench for fifo_read_adapter: vector table, directed corner
// sequences and random traffic against a queue-based model.
module tb_fifo_read_adapter;
   localparam int DW = 16;
   localparam int D  = 2;
   localparam int M_IDLE = 0;
   localparam int M_ACT  = 1;
   localparam int M_FLS  = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_en;
   logic        flush;
   logic        enable;
   logic [31:0] pop_cnt;
   logic        err_spurious;
   logic        err_overflow;

   fifo_read_adapter_if #(.DATA_WIDTH(DW)) bus ();

   fifo_read_adapter #(.DATA_WIDTH(DW), .BUF_DEPTH(D)) dut (
      .clk          (clk),
      .reset        (reset),
      .clk_en       (clk_en),
      .flush        (flush),
      .enable       (enable),
      .bus          (bus),
      .pop_cnt      (pop_cnt),
      .err_spurious (err_spurious),
      .err_overflow (err_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          ce, fl, en, em, mv;
      logic [15:0] md;
      bit          rdy, aut, chk;
      bit          e_ren, e_vld;
      logic [15:0] e_data;
      int          e_pc;
   } vec_t;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] mq[$];
   logic [15:0] popped[$];
   int          m_mode;
   bit          m_inf, m_sp, m_ov;
   logic [31:0] m_pc;
   bit          prev_ren;
   logic [15:0] seq;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(bit ce, bit fl, bit en, bit em, bit mv,
                               logic [15:0] md, bit rdy, bit e_ren,
                               bit e_vld, logic [15:0] e_data, int e_pc);
      vec_t v;
      v.ce = ce; v.fl = fl; v.en = en; v.em = em; v.mv = mv; v.md = md;
      v.rdy = rdy; v.aut = 1'b0; v.chk = 1'b1;
      v.e_ren = e_ren; v.e_vld = e_vld; v.e_data = e_data; v.e_pc = e_pc;
      return v;
   endfunction

   function automatic vec_t av(bit ce, bit fl, bit en, bit em, bit mv,
                               logic [15:0] md, bit rdy);
      vec_t v;
      v = mk(ce, fl, en, em, mv, md, rdy, 1'b0, 1'b0, 16'h0, 0);
      v.aut = 1'b1; v.chk = 1'b0;
      return v;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_mode = M_IDLE; m_inf = 0; m_sp = 0; m_ov = 0;
      m_pc = '0; prev_ren = 0;
   endtask

   task automatic step(input vec_t v);
      bit r, vl, p, acc;
      int sz;
      logic [15:0] hd;
      @(posedge clk);
      #1;
      clk_en = v.ce; flush = v.fl; enable = v.en;
      bus.empty = v.em; bus.out_ready = v.rdy;
      if (v.aut) begin
         bus.mem_valid_out = prev_ren | v.mv;
         bus.mem_data_out  = prev_ren ? seq : v.md;
         if (prev_ren) seq++;
      end else begin
         bus.mem_valid_out = v.mv;
         bus.mem_data_out  = v.md;
      end
      @(negedge clk);
      sz = mq.size();
      vl = v.ce && (sz != 0);
      hd = vl ? mq[0] : 16'h0;
      r  = v.ce && !v.fl && !v.em && (m_mode == M_ACT) && v.en
           && ((sz + int'(m_inf)) < D);
      chk("ren_in", bus.ren_in, r);
      chk("out_valid", bus.out_valid, vl);
      if (vl) chk("out_data", bus.out_data, hd);
      chk("pop_cnt", pop_cnt, m_pc);
      chk("err_spurious", err_spurious, m_sp);
      chk("err_overflow", err_overflow, m_ov);
      if (v.chk) begin
         chk("tbl_ren", bus.ren_in, v.e_ren);
         chk("tbl_valid", bus.out_valid, v.e_vld);
         if (v.e_vld) chk("tbl_data", bus.out_data, v.e_data);
         chk("tbl_pop_cnt", pop_cnt, v.e_pc);
      end
      if (v.ce) begin
         p   = vl && v.rdy && !v.fl;
         acc = bus.mem_valid_out && !v.fl && (m_mode != M_FLS);
         if (p) begin
            popped.push_back(bus.out_data);
            void'(mq.pop_front());
            m_pc++;
         end
         if (acc) begin
            if (!m_inf) m_sp = 1;
            if (sz < D || p) mq.push_back(bus.mem_data_out);
            else m_ov = 1;
         end
         if (v.fl) begin
            mq.delete();
            m_mode = M_FLS;
         end else begin
            case (m_mode)
               M_IDLE:  if (v.en) m_mode = M_ACT;
               M_ACT:   if (!v.en && !m_inf) m_mode = M_IDLE;
               default: m_mode = M_IDLE;
            endcase
         end
         m_inf = r;
      end
      prev_ren = r;
   endtask

   task automatic hard_reset();
      @(negedge clk);
      #2;
      reset = 1'b1;
      clk_en = 1'b1; flush = 1'b0; enable = 1'b0;
      bus.empty = 1'b1; bus.mem_valid_out = 1'b0;
      bus.mem_data_out = '0; bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   vec_t tbl[$];
   vec_t v;
   int   issued;

   initial begin
      reset = 1'b1;
      clk_en = 1'b1; flush = 1'b0; enable = 1'b0;
      bus.empty = 1'b1; bus.mem_valid_out = 1'b0;
      bus.mem_data_out = '0; bus.out_ready = 1'b0;
      seq = 16'h0001;
      model_reset();
      #12;
      chk("rst_ren", bus.ren_in, 1'b0);
      chk("rst_valid", bus.out_valid, 1'b0);
      chk("rst_data", bus.out_data, 16'h0);
      chk("rst_pop_cnt", pop_cnt, 32'h0);
      chk("rst_err_sp", err_spurious, 1'b0);
      chk("rst_err_ov", err_overflow, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // ce fl en em mv md rdy | ren vld data pc
      tbl.push_back(mk(1,0,1,0,0,16'h0,  1, 0,0,16'h0,  0));
      tbl.push_back(mk(1,0,1,0,0,16'h0,  1, 1,0,16'h0,  0));
      tbl.push_back(mk(1,0,1,0,1,16'hA1, 1, 1,0,16'h0,  0));
      tbl.push_back(mk(1,0,1,0,1,16'hA2, 1, 0,1,16'hA1, 0));
      tbl.push_back(mk(1,0,1,0,0,16'h0,  0, 1,1,16'hA2, 1));
      tbl.push_back(mk(1,0,1,0,1,16'hA3, 0, 0,1,16'hA2, 1));
      tbl.push_back(mk(1,0,1,0,0,16'h0,  0, 0,1,16'hA2, 1));
      tbl.push_back(mk(1,0,1,0,0,16'h0,  0, 0,1,16'hA2, 1));
      tbl.push_back(mk(1,0,1,0,0,16'h0,  1, 0,1,16'hA2, 1));
      tbl.push_back(mk(1,0,0,0,0,16'h0,  1, 0,1,16'hA3, 2));
      tbl.push_back(mk(1,0,1,1,0,16'h0,  1, 0,0,16'h0,  3));
      tbl.push_back(mk(1,0,1,1,0,16'h0,  1, 0,0,16'h0,  3));
      tbl.push_back(mk(1,0,1,0,0,16'h0,  1, 1,0,16'h0,  3));
      tbl.push_back(mk(1,0,1,1,1,16'hA4, 1, 0,0,16'h0,  3));
      tbl.push_back(mk(1,0,1,1,0,16'h0,  1, 0,1,16'hA4, 3));
      tbl.push_back(mk(0,0,1,0,0,16'h0,  1, 0,0,16'h0,  4));
      foreach (tbl[i]) step(tbl[i]);

      // stream of eight words 0x0001..0x0008
      hard_reset();
      popped.delete();
      seq = 16'h0001;
      issued = 0;
      for (int n = 0; n < 60 && popped.size() < 8; n++) begin
         step(av(1,0,(issued < 8),0,0,16'h0,1));
         issued += int'(prev_ren);
      end
      step(av(1,0,0,0,0,16'h0,1));
      chk("stream_pop_cnt", pop_cnt, 32'd8);
      chk("stream_count", popped.size(), 8);
      for (int i = 0; i < popped.size() && i < 8; i++)
         chk("stream_word", popped[i], 32'(i + 1));
      step(av(1,0,0,0,0,16'h0,1));
      step(av(1,0,0,0,0,16'h0,1));

      // flush with data buffered and a read outstanding
      step(av(1,0,1,0,0,16'h0,0));
      step(av(1,0,1,0,0,16'h0,0));
      step(av(1,0,1,0,0,16'h0,0));
      step(av(1,1,1,0,0,16'h0,1));
      chk("flush_cycle_valid", bus.out_valid, 1'b1);
      step(av(1,0,1,0,1,16'hEE,1));
      chk("post_flush_valid", bus.out_valid, 1'b0);
      chk("post_flush_ren", bus.ren_in, 1'b0);
      chk("post_flush_pop_cnt", pop_cnt, 32'd8);
      step(av(1,0,0,0,0,16'h0,1));
      chk("flush_err_sp", err_spurious, 1'b0);
      chk("flush_err_ov", err_overflow, 1'b0);
      chk("flush_dropped", bus.out_valid, 1'b0);

      // spurious write, full-with-pop accept, then overflow drop
      step(av(1,0,0,0,1,16'h0055,0));
      step(av(1,0,0,0,1,16'h0066,0));
      chk("spurious_set", err_spurious, 1'b1);
      chk("spurious_data", bus.out_data, 16'h0055);
      step(av(1,0,0,0,1,16'h0077,1));
      chk("full_pop_no_ovf", err_overflow, 1'b0);
      step(av(1,0,0,0,1,16'h0088,0));
      step(av(1,0,0,0,0,16'h0,1));
      chk("overflow_set", err_overflow, 1'b1);
      chk("ovf_head", bus.out_data, 16'h0066);
      step(av(1,0,0,0,0,16'h0,1));
      chk("ovf_dropped", bus.out_data, 16'h0077);
      step(av(1,0,0,0,0,16'h0,1));
      chk("drained", bus.out_valid, 1'b0);
      chk("spurious_sticky", err_spurious, 1'b1);
      chk("pop_cnt_11", pop_cnt, 32'd11);

      // random traffic
      for (int n = 0; n < 2500; n++) begin
         v = av(($urandom % 10) != 0, ($urandom % 40) == 0,
                ($urandom % 8) != 0, ($urandom % 4) == 0,
                ($urandom % 50) == 0, 16'($urandom),
                ($urandom % 3) != 0);
         step(v);
      end

      // reset with one word buffered and three pops done
      hard_reset();
      step(av(1,0,0,0,1,16'h0001,0));
      step(av(1,0,0,0,1,16'h0002,1));
      step(av(1,0,0,0,1,16'h0003,1));
      step(av(1,0,0,0,1,16'h0004,1));
      step(av(1,0,0,0,0,16'h0,0));
      chk("pre_rst_pop_cnt", pop_cnt, 32'd3);
      chk("pre_rst_valid", bus.out_valid, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_valid", bus.out_valid, 1'b0);
      chk("async_rst_pop_cnt", pop_cnt, 32'h0);
      chk("async_rst_data", bus.out_data, 16'h0);
      chk("async_rst_err_sp", err_spurious, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      step(av(1,0,1,0,0,16'h0,1));
      chk("idle_no_ren", bus.ren_in, 1'b0);
      step(av(1,0,1,0,0,16'h0,1));
      chk("first_ren", bus.ren_in, 1'b1);
      step(av(1,0,1,0,0,16'h0,1));
      step(av(1,0,0,0,0,16'h0,1));
      step(av(1,0,0,0,0,16'h0,1));

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
